// File: rtl/mc_ctrl_pkg.sv
// mc_ctrl_pkg: shared types and constants for the multicycle RISC-V control FSM.
// Holds the state enum, opcode/funct field values, datapath select encodings,
// trap causes, and decode helpers used by mc_ctrl_fsm.
package mc_ctrl_pkg;

  typedef enum logic [3:0] {
    FETCH,
    DECODE,
    EXEC_R,
    EXEC_I,
    ADDR,
    WB_ALU,
    MEM_RD,
    WB_MEM,
    MEM_WR,
    BRANCH,
    LUI,
    TRAP,
    HALT
  } stateT;

  // Opcodes
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;

  // funct3 / funct7
  localparam logic [2:0] F3_ADD = 3'b000;
  localparam logic [2:0] F3_AND = 3'b111;
  localparam logic [2:0] F3_OR  = 3'b110;
  localparam logic [2:0] F3_LSW = 3'b010;
  localparam logic [2:0] F3_BEQ = 3'b000;
  localparam logic [2:0] F3_BNE = 3'b001;
  localparam logic [2:0] F3_BLT = 3'b100;
  localparam logic [2:0] F3_BGE = 3'b101;
  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  // ALU operations
  localparam logic [2:0] ALU_PASS = 3'd0;
  localparam logic [2:0] ALU_ADD  = 3'd1;
  localparam logic [2:0] ALU_SUB  = 3'd2;
  localparam logic [2:0] ALU_AND  = 3'd3;
  localparam logic [2:0] ALU_OR   = 3'd4;

  // PC source
  localparam logic [1:0] PC_SRC_ALU    = 2'd0;
  localparam logic [1:0] PC_SRC_ALUOUT = 2'd1;
  localparam logic [1:0] PC_SRC_TRAP   = 2'd2;

  // Writeback source
  localparam logic [1:0] WB_ALUOUT = 2'd0;
  localparam logic [1:0] WB_MDR    = 2'd1;
  localparam logic [1:0] WB_UIMM   = 2'd2;

  // ALU operand selects
  localparam logic [1:0] SRCA_PC    = 2'd0;
  localparam logic [1:0] SRCA_REG   = 2'd1;
  localparam logic [1:0] SRCA_OLDPC = 2'd2;
  localparam logic [1:0] SRCB_REG   = 2'd0;
  localparam logic [1:0] SRCB_FOUR  = 2'd1;
  localparam logic [1:0] SRCB_IMM   = 2'd2;

  // Trap causes
  localparam logic [1:0] CAUSE_NONE    = 2'd0;
  localparam logic [1:0] CAUSE_ILLEGAL = 2'd1;
  localparam logic [1:0] CAUSE_BUS     = 2'd2;

  // State that follows DECODE for a given instruction word. Anything not
  // recognised (including blt/bge when they are disabled) lands in TRAP.
  function automatic stateT decodeTarget(input logic [31:0] ir, input logic hasBltBge);
    logic [6:0] opc;
    logic [2:0] f3;
    logic [6:0] f7;
    stateT nxt;
    opc = ir[6:0];
    f3  = ir[14:12];
    f7  = ir[31:25];
    nxt = TRAP;
    if (ir == 32'h0) begin
      nxt = HALT;
    end else begin
      case (opc)
        OPC_OP: begin
          if ((f3 == F3_ADD && (f7 == F7_BASE || f7 == F7_ALT)) ||
              ((f3 == F3_AND || f3 == F3_OR) && f7 == F7_BASE))
            nxt = EXEC_R;
        end
        OPC_OPIMM:  if (f3 == F3_ADD) nxt = EXEC_I;
        OPC_LOAD:   if (f3 == F3_LSW) nxt = ADDR;
        OPC_STORE:  if (f3 == F3_LSW) nxt = ADDR;
        OPC_BRANCH: begin
          if (f3 == F3_BEQ || f3 == F3_BNE)
            nxt = BRANCH;
          else if ((f3 == F3_BLT || f3 == F3_BGE) && hasBltBge)
            nxt = BRANCH;
        end
        OPC_LUI:    nxt = LUI;
        default:    nxt = TRAP;
      endcase
    end
    return nxt;
  endfunction

  // R-type ALU op; only called for encodings decodeTarget accepted.
  function automatic logic [2:0] rTypeAluOp(input logic [2:0] f3, input logic f7Alt);
    logic [2:0] op;
    case (f3)
      F3_AND:  op = ALU_AND;
      F3_OR:   op = ALU_OR;
      default: op = f7Alt ? ALU_SUB : ALU_ADD;
    endcase
    return op;
  endfunction

  function automatic logic branchTaken(input logic [2:0] f3, input logic zero, input logic lt);
    logic taken;
    case (f3)
      F3_BEQ:  taken = zero;
      F3_BNE:  taken = !zero;
      F3_BLT:  taken = lt;
      F3_BGE:  taken = !lt;
      default: taken = 1'b0;
    endcase
    return taken;
  endfunction

endpackage

// File: rtl/mc_timeout_cnt.sv
// mc_timeout_cnt: 8-bit memory wait counter for the bus-timeout trap.
// Ports:
//   clk, rst  - clock, synchronous active-high reset
//   en        - a request is outstanding and unanswered this cycle
//   clr       - restart the count (answered, or outside a memory state)
//   expired   - this waiting cycle is the LIMIT-th one in a row
module mc_timeout_cnt #(
  parameter int LIMIT = 15
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic expired
);

  localparam logic [7:0] LAST = 8'(LIMIT - 1);

  logic [7:0] count;

  always_ff @(posedge clk) begin
    if (rst || clr)
      count <= '0;
    else if (en)
      count <= count + 8'd1;
  end

  // count holds the waits already seen, so the limit is reached by the
  // increment that would happen this cycle.
  assign expired = en && (count == LAST);

endmodule

// File: rtl/mc_ctrl_fsm.sv
// mc_ctrl_fsm: multicycle control FSM for the RISC-V datapath with memory
// ready/request handshake, bus timeout and illegal-opcode trap.
// Ports:
//   clk, rst               - clock, synchronous active-high reset
//   instr                  - IR contents
//   alu_zero, alu_lt       - ALU flags for branch resolution
//   mem_ready              - memory completes the current request
//   mem_req/we/addr_sel    - memory control
//   pc_write, pc_src       - PC load and source
//   *_load                 - datapath register load enables
//   reg_write, wb_sel      - register file write and source
//   alu_src_a/b, alu_op    - ALU operand selects and operation
//   trap, trap_cause       - trap pulse and sticky cause
//   halted                 - FSM is in HALT
//
// state  | meaning
// FETCH  | read instruction, PC += 4 on ready
// DECODE | load A/B, compute branch target into ALUOut
// EXEC_R | register-register ALU op
// EXEC_I | register-immediate add
// ADDR   | effective address for load/store
// WB_ALU | write ALUOut to rd
// MEM_RD | load data read, MDR on ready
// WB_MEM | write MDR to rd
// MEM_WR | store data write
// BRANCH | compare, redirect PC if taken
// LUI    | write U-immediate to rd
// TRAP   | redirect PC to trap vector
// HALT   | stopped until reset
module mc_ctrl_fsm
  import mc_ctrl_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 15,
  parameter bit HAS_BLT_BGE    = 1'b1,
  parameter bit HALT_ON_TRAP   = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] instr,
  input  logic        alu_zero,
  input  logic        alu_lt,
  input  logic        mem_ready,
  output logic        mem_req,
  output logic        mem_we,
  output logic        mem_addr_sel,
  output logic        pc_write,
  output logic [1:0]  pc_src,
  output logic        ir_load,
  output logic        old_pc_load,
  output logic        reg_a_load,
  output logic        reg_b_load,
  output logic        aluout_load,
  output logic        mdr_load,
  output logic        reg_write,
  output logic [1:0]  wb_sel,
  output logic [1:0]  alu_src_a,
  output logic [1:0]  alu_src_b,
  output logic [2:0]  alu_op,
  output logic        trap,
  output logic [1:0]  trap_cause,
  output logic        halted
);

  stateT      state;
  stateT      decodeNext;
  logic [1:0] trapCause;
  logic       inMemState;
  logic       tmoEn;
  logic       tmoClr;
  logic       tmoExpired;

  assign decodeNext = decodeTarget(instr, HAS_BLT_BGE);
  assign inMemState = (state == FETCH) || (state == MEM_RD) || (state == MEM_WR);
  assign tmoEn      = mem_req & ~mem_ready;
  // Clearing while outside the memory states guarantees each request
  // starts counting from zero; clearing on expiry covers entry to TRAP.
  assign tmoClr     = mem_ready | tmoExpired | ~inMemState;

  mc_timeout_cnt #(
    .LIMIT(TIMEOUT_CYCLES)
  ) uTimeout (
    .clk    (clk),
    .rst    (rst),
    .en     (tmoEn),
    .clr    (tmoClr),
    .expired(tmoExpired)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= FETCH;
      trapCause <= CAUSE_NONE;
    end else begin
      case (state)
        FETCH: begin
          if (mem_ready) begin
            state <= DECODE;
          end else if (tmoExpired) begin
            state     <= TRAP;
            trapCause <= CAUSE_BUS;
          end
        end
        DECODE: begin
          state <= decodeNext;
          if (decodeNext == TRAP)
            trapCause <= CAUSE_ILLEGAL;
        end
        EXEC_R, EXEC_I: state <= WB_ALU;
        ADDR:   state <= (instr[6:0] == OPC_STORE) ? MEM_WR : MEM_RD;
        MEM_RD: begin
          if (mem_ready) begin
            state <= WB_MEM;
          end else if (tmoExpired) begin
            state     <= TRAP;
            trapCause <= CAUSE_BUS;
          end
        end
        MEM_WR: begin
          if (mem_ready) begin
            state <= FETCH;
          end else if (tmoExpired) begin
            state     <= TRAP;
            trapCause <= CAUSE_BUS;
          end
        end
        WB_ALU, WB_MEM, BRANCH, LUI: state <= FETCH;
        TRAP:    state <= HALT_ON_TRAP ? HALT : FETCH;
        HALT:    state <= HALT;
        default: state <= FETCH;
      endcase
    end
  end

  // Outputs decode from state; forced to 0 during rst so an abandoned
  // instruction cannot write memory or registers in the reset cycle.
  always_comb begin
    mem_req      = 1'b0;
    mem_we       = 1'b0;
    mem_addr_sel = 1'b0;
    pc_write     = 1'b0;
    pc_src       = PC_SRC_ALU;
    ir_load      = 1'b0;
    old_pc_load  = 1'b0;
    reg_a_load   = 1'b0;
    reg_b_load   = 1'b0;
    aluout_load  = 1'b0;
    mdr_load     = 1'b0;
    reg_write    = 1'b0;
    wb_sel       = WB_ALUOUT;
    alu_src_a    = SRCA_PC;
    alu_src_b    = SRCB_REG;
    alu_op       = ALU_PASS;
    trap         = 1'b0;
    trap_cause   = CAUSE_NONE;
    halted       = 1'b0;
    if (!rst) begin
      trap_cause = trapCause;
      case (state)
        FETCH: begin
          mem_req   = 1'b1;
          alu_src_a = SRCA_PC;
          alu_src_b = SRCB_FOUR;
          alu_op    = ALU_ADD;
          if (mem_ready) begin
            ir_load     = 1'b1;
            old_pc_load = 1'b1;
            pc_write    = 1'b1;
            pc_src      = PC_SRC_ALU;
          end
        end
        DECODE: begin
          reg_a_load  = 1'b1;
          reg_b_load  = 1'b1;
          aluout_load = 1'b1;
          alu_src_a   = SRCA_OLDPC;
          alu_src_b   = SRCB_IMM;
          alu_op      = ALU_ADD;
        end
        EXEC_R: begin
          alu_src_a   = SRCA_REG;
          alu_src_b   = SRCB_REG;
          aluout_load = 1'b1;
          alu_op      = rTypeAluOp(instr[14:12], instr[30]);
        end
        EXEC_I, ADDR: begin
          alu_src_a   = SRCA_REG;
          alu_src_b   = SRCB_IMM;
          alu_op      = ALU_ADD;
          aluout_load = 1'b1;
        end
        WB_ALU: begin
          reg_write = 1'b1;
          wb_sel    = WB_ALUOUT;
        end
        MEM_RD: begin
          mem_req      = 1'b1;
          mem_addr_sel = 1'b1;
          mdr_load     = mem_ready;
        end
        WB_MEM: begin
          reg_write = 1'b1;
          wb_sel    = WB_MDR;
        end
        MEM_WR: begin
          mem_req      = 1'b1;
          mem_we       = 1'b1;
          mem_addr_sel = 1'b1;
        end
        BRANCH: begin
          alu_src_a = SRCA_REG;
          alu_src_b = SRCB_REG;
          alu_op    = ALU_SUB;
          pc_src    = PC_SRC_ALUOUT;
          pc_write  = branchTaken(instr[14:12], alu_zero, alu_lt);
        end
        LUI: begin
          reg_write = 1'b1;
          wb_sel    = WB_UIMM;
        end
        TRAP: begin
          trap     = 1'b1;
          pc_write = 1'b1;
          pc_src   = PC_SRC_TRAP;
        end
        HALT:    halted = 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
module tb_mc_ctrl_fsm;

  typedef struct packed {
    logic       memReq;
    logic       memWe;
    logic       memAddrSel;
    logic       pcWrite;
    logic [1:0] pcSrc;
    logic       irLoad;
    logic       oldPcLoad;
    logic       regALoad;
    logic       regBLoad;
    logic       aluoutLoad;
    logic       mdrLoad;
    logic       regWrite;
    logic [1:0] wbSel;
    logic [1:0] aluSrcA;
    logic [1:0] aluSrcB;
    logic [2:0] aluOp;
    logic       trap;
    logic [1:0] trapCause;
    logic       halted;
  } outT;

  typedef struct {
    logic        rst;
    logic [31:0] instr;
    logic        rdy;
    logic        z;
    logic        lt;
    outT         exp;
  } vecT;

  localparam logic [31:0] I_ADD   = 32'h002081B3;
  localparam logic [31:0] I_SUB   = 32'h402081B3;
  localparam logic [31:0] I_AND   = 32'h0020F1B3;
  localparam logic [31:0] I_OR    = 32'h0020E1B3;
  localparam logic [31:0] I_BADR  = 32'h202081B3;
  localparam logic [31:0] I_ADDI  = 32'h00500093;
  localparam logic [31:0] I_LW    = 32'h0000A283;
  localparam logic [31:0] I_SW    = 32'h0050A023;
  localparam logic [31:0] I_BEQ   = 32'h00208063;
  localparam logic [31:0] I_BNE   = 32'h00209063;
  localparam logic [31:0] I_BLT   = 32'h0020C063;
  localparam logic [31:0] I_BGE   = 32'h0020D063;
  localparam logic [31:0] I_BADBR = 32'h0020A063;
  localparam logic [31:0] I_LUI   = 32'h000012B7;
  localparam logic [31:0] I_ILL   = 32'hFFFFFFFF;
  localparam logic [31:0] I_HALT  = 32'h00000000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] instr = '0;
  logic        aluZero = 1'b0;
  logic        aluLt = 1'b0;
  logic        memReady = 1'b0;

  logic memReq, memWe, memAddrSel, pcWrite, irLoad, oldPcLoad, regALoad, regBLoad;
  logic aluoutLoad, mdrLoad, regWrite, trap, halted;
  logic [1:0] pcSrc, wbSel, aluSrcA, aluSrcB, trapCause;
  logic [2:0] aluOp;

  logic memReq2, memWe2, memAddrSel2, pcWrite2, irLoad2, oldPcLoad2, regALoad2, regBLoad2;
  logic aluoutLoad2, mdrLoad2, regWrite2, trap2, halted2;
  logic [1:0] pcSrc2, wbSel2, aluSrcA2, aluSrcB2, trapCause2;
  logic [2:0] aluOp2;

  outT act, act2;
  assign act  = {memReq, memWe, memAddrSel, pcWrite, pcSrc, irLoad, oldPcLoad, regALoad,
                 regBLoad, aluoutLoad, mdrLoad, regWrite, wbSel, aluSrcA, aluSrcB, aluOp,
                 trap, trapCause, halted};
  assign act2 = {memReq2, memWe2, memAddrSel2, pcWrite2, pcSrc2, irLoad2, oldPcLoad2, regALoad2,
                 regBLoad2, aluoutLoad2, mdrLoad2, regWrite2, wbSel2, aluSrcA2, aluSrcB2, aluOp2,
                 trap2, trapCause2, halted2};

  always #5 clk = ~clk;

  // Main instance: blt/bge decoded, traps return to FETCH.
  mc_ctrl_fsm #(.TIMEOUT_CYCLES(15), .HAS_BLT_BGE(1'b1), .HALT_ON_TRAP(1'b0)) dut (
    .clk(clk), .rst(rst), .instr(instr), .alu_zero(aluZero), .alu_lt(aluLt),
    .mem_ready(memReady), .mem_req(memReq), .mem_we(memWe), .mem_addr_sel(memAddrSel),
    .pc_write(pcWrite), .pc_src(pcSrc), .ir_load(irLoad), .old_pc_load(oldPcLoad),
    .reg_a_load(regALoad), .reg_b_load(regBLoad), .aluout_load(aluoutLoad),
    .mdr_load(mdrLoad), .reg_write(regWrite), .wb_sel(wbSel), .alu_src_a(aluSrcA),
    .alu_src_b(aluSrcB), .alu_op(aluOp), .trap(trap), .trap_cause(trapCause),
    .halted(halted));

  // Second instance: blt/bge illegal, traps halt.
  mc_ctrl_fsm #(.TIMEOUT_CYCLES(15), .HAS_BLT_BGE(1'b0), .HALT_ON_TRAP(1'b1)) dut2 (
    .clk(clk), .rst(rst), .instr(instr), .alu_zero(aluZero), .alu_lt(aluLt),
    .mem_ready(memReady), .mem_req(memReq2), .mem_we(memWe2), .mem_addr_sel(memAddrSel2),
    .pc_write(pcWrite2), .pc_src(pcSrc2), .ir_load(irLoad2), .old_pc_load(oldPcLoad2),
    .reg_a_load(regALoad2), .reg_b_load(regBLoad2), .aluout_load(aluoutLoad2),
    .mdr_load(mdrLoad2), .reg_write(regWrite2), .wb_sel(wbSel2), .alu_src_a(aluSrcA2),
    .alu_src_b(aluSrcB2), .alu_op(aluOp2), .trap(trap2), .trap_cause(trapCause2),
    .halted(halted2));

  int nChecks = 0;
  int nPass = 0;
  vecT vecs[$];
  logic [1:0] cc = 2'd0;
  logic fz = 1'b0;
  logic flt = 1'b0;

  // Expected output patterns, one per state.
  function automatic outT eZero();
    outT o = '0;
    return o;
  endfunction
  function automatic outT eFetch(input logic rdy);
    outT o = '0;
    o.memReq = 1; o.aluSrcB = 2'd1; o.aluOp = 3'd1;
    if (rdy) begin o.irLoad = 1; o.oldPcLoad = 1; o.pcWrite = 1; end
    return o;
  endfunction
  function automatic outT eDecode();
    outT o = '0;
    o.regALoad = 1; o.regBLoad = 1; o.aluoutLoad = 1;
    o.aluSrcA = 2'd2; o.aluSrcB = 2'd2; o.aluOp = 3'd1;
    return o;
  endfunction
  function automatic outT eExecR(input logic [2:0] op);
    outT o = '0;
    o.aluSrcA = 2'd1; o.aluoutLoad = 1; o.aluOp = op;
    return o;
  endfunction
  function automatic outT eExecI();
    outT o = '0;
    o.aluSrcA = 2'd1; o.aluSrcB = 2'd2; o.aluOp = 3'd1; o.aluoutLoad = 1;
    return o;
  endfunction
  function automatic outT eWb(input logic [1:0] sel);
    outT o = '0;
    o.regWrite = 1; o.wbSel = sel;
    return o;
  endfunction
  function automatic outT eMemRd(input logic rdy);
    outT o = '0;
    o.memReq = 1; o.memAddrSel = 1; o.mdrLoad = rdy;
    return o;
  endfunction
  function automatic outT eMemWr();
    outT o = '0;
    o.memReq = 1; o.memWe = 1; o.memAddrSel = 1;
    return o;
  endfunction
  function automatic outT eBranch(input logic taken);
    outT o = '0;
    o.aluSrcA = 2'd1; o.aluOp = 3'd2; o.pcSrc = 2'd1; o.pcWrite = taken;
    return o;
  endfunction
  function automatic outT eTrap();
    outT o = '0;
    o.trap = 1; o.pcWrite = 1; o.pcSrc = 2'd2;
    return o;
  endfunction
  function automatic outT eHalt();
    outT o = '0;
    o.halted = 1;
    return o;
  endfunction
  function automatic outT withCause(input outT e, input logic [1:0] c);
    outT o = e;
    o.trapCause = c;
    return o;
  endfunction

  task automatic r(input logic [31:0] ins, input logic rdy, input outT e);
    vecT v;
    v.rst = 1'b0; v.instr = ins; v.rdy = rdy; v.z = fz; v.lt = flt;
    v.exp = withCause(e, cc);
    vecs.push_back(v);
  endtask
  task automatic rr();
    vecT v;
    v.rst = 1'b1; v.instr = I_ADD; v.rdy = 1'b1; v.z = 1'b0; v.lt = 1'b0;
    v.exp = eZero();
    vecs.push_back(v);
  endtask
  task automatic fd(input logic [31:0] ins);
    r(ins, 1'b1, eFetch(1'b1));
    r(ins, 1'b1, eDecode());
  endtask

  task automatic chk(input string nm, input int idx, input outT a, input outT e);
    nChecks++;
    if (a === e) nPass++;
    else $display("FAIL %s[%0d] got=%h want=%h", nm, idx, a, e);
  endtask
  task automatic chkVal(input string nm, input int a, input int e);
    nChecks++;
    if (a == e) nPass++;
    else $display("FAIL %s got=%0d want=%0d", nm, a, e);
  endtask

  task automatic cyc(input logic rs, input logic [31:0] ins, input logic rdy);
    @(negedge clk);
    rst = rs; instr = ins; memReady = rdy; aluZero = fz; aluLt = flt;
    #1;
  endtask

  initial begin
    int trapAt;
    int stableBad;

    // ---- vector table ----
    rr(); rr();
    fd(I_ADD);  r(I_ADD, 1, eExecR(3'd1));  r(I_ADD, 1, eWb(2'd0));
    fd(I_SUB);  r(I_SUB, 1, eExecR(3'd2));  r(I_SUB, 1, eWb(2'd0));
    fd(I_AND);  r(I_AND, 1, eExecR(3'd3));  r(I_AND, 1, eWb(2'd0));
    fd(I_OR);   r(I_OR,  1, eExecR(3'd4));  r(I_OR,  1, eWb(2'd0));
    fd(I_ADDI); r(I_ADDI, 1, eExecI());     r(I_ADDI, 1, eWb(2'd0));
    fd(I_LW);   r(I_LW, 1, eExecI());
    for (int i = 0; i < 3; i++) r(I_LW, 0, eMemRd(1'b0));
    r(I_LW, 1, eMemRd(1'b1));               r(I_LW, 1, eWb(2'd1));
    fd(I_SW);   r(I_SW, 1, eExecI());       r(I_SW, 1, eMemWr());
    fd(I_SW);   r(I_SW, 1, eExecI());       r(I_SW, 0, eMemWr());  r(I_SW, 1, eMemWr());
    fz = 1; fd(I_BEQ); r(I_BEQ, 1, eBranch(1'b1));
    fz = 0; fd(I_BEQ); r(I_BEQ, 1, eBranch(1'b0));
    fz = 0; fd(I_BNE); r(I_BNE, 1, eBranch(1'b1));
    fz = 1; fd(I_BNE); r(I_BNE, 1, eBranch(1'b0));
    fz = 0; flt = 1; fd(I_BLT); r(I_BLT, 1, eBranch(1'b1));
    flt = 0; fd(I_BLT); r(I_BLT, 1, eBranch(1'b0));
    flt = 0; fd(I_BGE); r(I_BGE, 1, eBranch(1'b1));
    flt = 1; fd(I_BGE); r(I_BGE, 1, eBranch(1'b0));
    flt = 0;
    r(I_LUI, 0, eFetch(1'b0)); r(I_LUI, 0, eFetch(1'b0));
    fd(I_LUI);  r(I_LUI, 1, eWb(2'd2));
    fd(I_ILL);  cc = 2'd1; r(I_ILL, 1, eTrap());
    fd(I_BADBR); r(I_BADBR, 1, eTrap());
    fd(I_BADR);  r(I_BADR, 1, eTrap());
    fd(I_ADD);  r(I_ADD, 1, eExecR(3'd1));  r(I_ADD, 1, eWb(2'd0));
    fd(I_HALT); r(I_HALT, 1, eHalt());      r(I_HALT, 1, eHalt());
    cc = 2'd0; rr();
    r(I_ADD, 1, eFetch(1'b1));

    foreach (vecs[i]) begin
      @(negedge clk);
      rst = vecs[i].rst; instr = vecs[i].instr; memReady = vecs[i].rdy;
      aluZero = vecs[i].z; aluLt = vecs[i].lt;
      #1;
      chk("vec", i, act, vecs[i].exp);
    end

    // ---- bus timeout in FETCH: trap after 15 unanswered cycles ----
    fz = 0; flt = 0;
    cyc(1, I_ADDI, 0);
    trapAt = 0; stableBad = 0;
    for (int k = 1; k <= 30 && trapAt == 0; k++) begin
      cyc(0, I_ADDI, 0);
      if (trap) begin
        trapAt = k;
        chk("tmo_trap", k, act, withCause(eTrap(), 2'd2));
      end else if (act !== eFetch(1'b0)) begin
        stableBad++;
      end
    end
    chkVal("tmo_cycle", trapAt, 16);
    chkVal("tmo_req_stable", stableBad, 0);
    cyc(0, I_ADDI, 0);
    chk("tmo_refetch", 0, act, withCause(eFetch(1'b0), 2'd2));
    chk("tmo_halt2", 0, act2, withCause(eHalt(), 2'd2));

    // ---- ready on the limit cycle wins ----
    cyc(1, I_ADDI, 0);
    for (int k = 1; k <= 14; k++) cyc(0, I_ADDI, 0);
    cyc(0, I_ADDI, 1);
    chk("lim_ready", 15, act, eFetch(1'b1));
    cyc(0, I_ADDI, 1);
    chk("lim_decode", 16, act, eDecode());

    // ---- blt with blt/bge disabled ----
    flt = 1;
    cyc(1, I_BLT, 1);
    cyc(0, I_BLT, 1);
    cyc(0, I_BLT, 1);
    chk("nb_decode", 0, act2, eDecode());
    cyc(0, I_BLT, 1);
    chk("nb_trap", 0, act2, withCause(eTrap(), 2'd1));
    chk("blt_taken", 0, act, eBranch(1'b1));
    cyc(0, I_BLT, 1);
    chk("nb_halt", 0, act2, withCause(eHalt(), 2'd1));
    cyc(0, I_BLT, 1); cyc(0, I_BLT, 1);
    chk("nb_halt_hold", 0, act2, withCause(eHalt(), 2'd1));
    flt = 0;

    // ---- reset during MEM_WR ----
    cyc(1, I_ILL, 1);
    cyc(0, I_ILL, 1); cyc(0, I_ILL, 1); cyc(0, I_ILL, 1);
    chk("pre_trap", 0, act, withCause(eTrap(), 2'd1));
    cyc(0, I_SW, 1); cyc(0, I_SW, 1); cyc(0, I_SW, 0);
    cyc(0, I_SW, 0);
    chk("wr_wait", 0, act, withCause(eMemWr(), 2'd1));
    cyc(1, I_SW, 0);
    chk("wr_rst", 0, act, eZero());
    chkVal("wr_rst_we", int'(memWe), 0);
    cyc(0, I_SW, 1);
    chk("wr_after_rst", 0, act, eFetch(1'b1));

    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule
